// File: rtl/falling_char_pkg.sv
// Shared types for the falling-character lane engine: lane record,
// matcher state encoding and the bottom line that turns a lane into a miss.
package falling_char_pkg;

  localparam int PKG_Y_W      = 10;
  localparam int PKG_VEL_W    = 2;
  localparam int PKG_SCREEN_H = 480;
  localparam int PKG_CHAR_H   = 16;

  // Largest top line at which a glyph is still fully on screen.
  localparam int MISS_LINE = PKG_SCREEN_H - PKG_CHAR_H;

  // One falling character. Field widths track the engine's Y_W / VEL_W defaults.
  typedef struct packed {
    logic                 active;
    logic [7:0]           glyph;
    logic [PKG_Y_W-1:0]   y;
    logic [PKG_VEL_W-1:0] vel;
  } lane_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESOLVE
  } match_state_t;

endpackage

// File: rtl/lane_popcount.sv
// Counts how many lanes missed in the current frame.
module lane_popcount #(
  parameter int N  = 53,
  parameter int CW = 7
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  // Plain adder chain; the miss vector is only needed once per frame.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/falling_char_engine.sv
// Lane engine for the typing game: spawns, moves and matches falling glyphs,
// keeps hit/miss scores and exposes lane state to the renderer.
module falling_char_engine
  import falling_char_pkg::*;
#(
  parameter int N_LANE   = 53,
  parameter int LANE_W   = 6,
  parameter int Y_W      = PKG_Y_W,
  parameter int SCREEN_H = PKG_SCREEN_H,
  parameter int CHAR_H   = PKG_CHAR_H,
  parameter int VEL_W    = PKG_VEL_W,
  parameter int CNT_W    = 14,
  parameter int MAX_MISS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              run,
  input  logic              spawn_valid,
  output logic              spawn_ready,
  input  logic [LANE_W-1:0] spawn_lane,
  input  logic [7:0]        spawn_char,
  input  logic [VEL_W-1:0]  spawn_vel,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [7:0]        key_char,
  output logic              key_done,
  output logic              key_hit,
  output logic [LANE_W-1:0] key_lane,
  input  logic [LANE_W-1:0] rd_lane,
  output logic              rd_active,
  output logic [7:0]        rd_char,
  output logic [Y_W-1:0]    rd_y,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              game_over
);

  localparam logic [Y_W:0]    MISS_Y   = (Y_W+1)'(SCREEN_H - CHAR_H);
  localparam logic [LANE_W:0] LANE_END = (LANE_W+1)'(N_LANE);

  lane_t              lanes [N_LANE];
  match_state_t       state;
  logic [7:0]         key_lat;
  logic [LANE_W-1:0]  idx;
  logic [LANE_W-1:0]  best;
  logic [Y_W-1:0]     best_y;
  logic               best_valid;

  logic               move;
  logic               spawn_fire;
  logic               res_hit;
  logic               hit_clr;
  logic [Y_W:0]       y_next [N_LANE];
  logic [N_LANE-1:0]  miss_vec;
  logic [LANE_W:0]    miss_pop;
  logic               cand;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LANE_W:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-LANE_W){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign move        = frame_tick & run & ~game_over;
  assign spawn_ready = ({1'b0, spawn_lane} < LANE_END) && !lanes[spawn_lane].active && !game_over;
  assign spawn_fire  = spawn_valid & spawn_ready;
  assign key_ready   = (state == ST_IDLE) & ~game_over;

  // The chosen lane may have been missed or cleared while the scan ran.
  assign res_hit = best_valid && lanes[best].active && (lanes[best].glyph == key_lat) && !game_over;
  assign hit_clr = (state == ST_RESOLVE) & res_hit;
  assign cand    = lanes[idx].active && (lanes[idx].glyph == key_lat);

  // Renderer read port, zero latency; out-of-range lanes read as empty.
  always_comb begin
    rd_active = 1'b0;
    rd_char   = '0;
    rd_y      = '0;
    if ({1'b0, rd_lane} < LANE_END) begin
      rd_active = lanes[rd_lane].active;
      rd_char   = lanes[rd_lane].glyph;
      rd_y      = lanes[rd_lane].y;
    end
  end

  // Next position and miss flag per lane; a same-cycle hit clear suppresses the miss.
  always_comb begin
    for (int i = 0; i < N_LANE; i++) begin
      y_next[i]   = {1'b0, lanes[i].y} + (Y_W+1)'(lanes[i].vel) + (Y_W+1)'(1);
      miss_vec[i] = move && lanes[i].active && (y_next[i] > MISS_Y)
                    && !(hit_clr && (best == LANE_W'(i)));
    end
  end

  lane_popcount #(.N(N_LANE), .CW(LANE_W+1)) u_popcount (
    .bits  (miss_vec),
    .count (miss_pop)
  );

  // Lane array: hit clear has priority, then spawn, then per-frame motion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_LANE; i++) lanes[i] <= '0;
    end else begin
      for (int i = 0; i < N_LANE; i++) begin
        if (hit_clr && (best == LANE_W'(i))) begin
          lanes[i].active <= 1'b0;
        end else if (spawn_fire && (spawn_lane == LANE_W'(i))) begin
          lanes[i] <= '{active: 1'b1, glyph: spawn_char, y: '0, vel: spawn_vel};
        end else if (move && lanes[i].active) begin
          if (miss_vec[i]) lanes[i].active <= 1'b0;
          else             lanes[i].y      <= y_next[i][Y_W-1:0];
        end
      end
    end
  end

  // Miss scoring and the sticky game-over flag, which lags the count by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_count <= '0;
      game_over  <= 1'b0;
    end else begin
      miss_count <= sat_add(miss_count, miss_pop);
      if (miss_count >= CNT_W'(MAX_MISS)) game_over <= 1'b1;
    end
  end

  // Keystroke matcher: scan every lane for the lowest copy, then re-validate and clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      key_lat    <= '0;
      idx        <= '0;
      best       <= '0;
      best_y     <= '0;
      best_valid <= 1'b0;
      key_done   <= 1'b0;
      key_hit    <= 1'b0;
      key_lane   <= '0;
      hit_count  <= '0;
    end else begin
      key_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_valid && key_ready) begin
            key_lat    <= key_char;
            best_valid <= 1'b0;
            idx        <= '0;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cand && (!best_valid || (lanes[idx].y > best_y))) begin
            best       <= idx;
            best_y     <= lanes[idx].y;
            best_valid <= 1'b1;
          end
          if (idx == LANE_W'(N_LANE - 1)) state <= ST_RESOLVE;
          else                            idx   <= idx + 1'b1;
        end
        ST_RESOLVE: begin
          key_done <= 1'b1;
          key_hit  <= res_hit;
          if (res_hit) begin
            key_lane  <= best;
            hit_count <= sat_add(hit_count, (LANE_W+1)'(1));
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/falling_char_engine.md
Name: falling_char_engine

Overview:
Parametrised lane engine for the typing game. Holds N_LANE falling characters, each with its own glyph code, vertical position and speed. Spawns characters from the word generator and advances them once per video frame. Matches keystrokes against the lowest on-screen copy of a character, and counts hits and misses with a game-over limit. The VGA renderer reads lane state through a combinational read port; this block produces no pixels.

Parameters:
N_LANE, 53, number of character lanes (screen columns)
LANE_W, 6, lane index width, ceil(log2(N_LANE))
Y_W, 10, position width; must hold SCREEN_H
SCREEN_H, 480, visible lines
CHAR_H, 16, glyph height in lines
VEL_W, 2, speed code width; step per frame = code+1 pixels
CNT_W, 14, hit/miss counter width
MAX_MISS, 10, misses that trigger game_over

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at end of visible frame
run  in  1  1 = motion enabled, 0 = paused
spawn_valid  in  1  spawn request
spawn_ready  out  1  spawn_lane free and not game_over
spawn_lane  in  LANE_W  target lane
spawn_char  in  8  ASCII code
spawn_vel  in  VEL_W  speed code
key_valid  in  1  keystroke available
key_ready  out  1  matcher idle
key_char  in  8  ASCII of keystroke
key_done  out  1  one-cycle pulse, match result valid
key_hit  out  1  match found (qualified by key_done)
key_lane  out  LANE_W  matched lane (qualified by key_hit)
rd_lane  in  LANE_W  renderer lane select
rd_active  out  1  lane occupied
rd_char  out  8  lane glyph
rd_y  out  Y_W  lane top line
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter
game_over  out  1  sticky; miss_count >= MAX_MISS

Behaviour:
- Reset (async, reset=0): all active=0, char=0, y=0, vel=0, counters=0, game_over=0, FSM=IDLE, key_done=0, key_hit=0, key_lane=0.
- Spawn: handshake fires when spawn_valid & spawn_ready. Lane written on that edge with active=1, y=0, char, vel. spawn_ready is combinational: !active[spawn_lane] & !game_over. Out-of-range lane (>=N_LANE) gives spawn_ready=0.
- Motion: on frame_tick & run & !game_over, every active lane updates in parallel: y_new = y + vel + 1, computed at Y_W+1 bits.
- Miss: if y_new > SCREEN_H-CHAR_H (464 by default), the lane is cleared to active=0. miss_count adds the popcount of lanes missing that frame, saturating at all-ones.
- game_over: sets on the cycle after miss_count >= MAX_MISS. Cleared only by reset. Freezes motion, spawns and keys; key_ready=0.
- Matcher FSM, states IDLE, SCAN, RESOLVE:
  - IDLE: key_ready=1. key_valid latches key_char, clears best_valid, sets idx=0, and goes to SCAN.
  - SCAN: one lane per cycle. Lane idx is a candidate if active & char==key. It replaces the best when !best_valid or y > best_y (strict, so on ties the lowest index wins). After idx=N_LANE-1, go to RESOLVE.
  - RESOLVE: re-check that the best lane is still active and its char still equals the latched key. If so: clear the lane, key_hit=1, key_lane=best, hit_count+1 (saturating). key_done pulses for one cycle either way. Return to IDLE.
  - Latency from key accept to key_done is N_LANE+1 cycles.
- Same-cycle events:
  - Hit clear and frame_tick on the same lane: the clear wins and no miss is counted.
  - Miss clear during SCAN of the chosen lane: RESOLVE reports key_hit=0.
  - Spawn cannot collide with an occupied lane, because spawn_ready is 0 while the lane is active.
  - Spawn accepted on a frame_tick edge: the lane loads y=0 and does not advance that frame.
- Read port is purely combinational from lane registers, zero latency.

Decomposition:
- falling_char_pkg: lane record type {active, char[7:0], y, vel}, FSM state enum, and constant MISS_LINE = SCREEN_H-CHAR_H.
- One sub-module is natural: lane_popcount (N_LANE-bit miss vector to count), instantiated once.
- FSM and lane array stay in the top module.

Test Plan:
1. Reset at mid-SCAN (reset=0 for 1 cycle) -> all outputs 0, key_ready=1, rd_active=0 for every lane.
2. Spawn lane 5 'A', vel 3; then 115 frame_ticks with run=1 -> rd_y=460, active. 116th tick -> y_new 464 stays active. 117th tick (468 > 464) -> lane cleared, miss_count=1.
3. Lanes 2 and 9 hold 'K' at y=100 and y=40; key 'K' -> after 54 cycles key_done=1, key_hit=1, key_lane=2, hit_count=1, lane 2 inactive, lane 9 untouched.
4. Lanes 3 and 7 both 'Q' at y=50; key 'Q' -> key_lane=3. Key 'Z' with no match -> key_done=1, key_hit=0, counters unchanged.
5. Spawn to active lane 5 -> spawn_ready=0, lane unchanged. Spawn with frame_tick on the same edge to free lane 6 -> rd_y=0 after the edge.
6. Ten lanes all reach bottom on one tick with MAX_MISS=10 -> miss_count=10, game_over=1 next cycle. Further spawn_valid/key_valid/frame_tick are ignored.
